// File: rtl/common.sv
// Shared types for the RV64 core pipeline: execute/memory bundles, data-bus
// request/response and the memory-stage FSM state.
package common;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_LD  = 4'd5,
    OP_SD  = 4'd6,
    OP_SW  = 4'd7,
    OP_SH  = 4'd8,
    OP_SB  = 4'd9
  } decoded_op_t;

  typedef struct packed {
    decoded_op_t op;
  } control_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    addr_t      pc;
    control_t   ctl;
    creg_addr_t dst;
    addr_t      mem_addr;
    word_t      result;
  } execute_data_t;

  typedef struct packed {
    addr_t      pc;
    control_t   ctl;
    creg_addr_t dst;
    word_t      result;
  } memory_data_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } mem_state_t;

  function automatic logic is_mem_op(input decoded_op_t op);
    return (op == OP_LD) || (op == OP_SD) || (op == OP_SW) ||
           (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational store alignment: bus size, byte strobes, lane-shifted data and
// misalignment flag. The flag is only raised when MEM_MISALIGN_CHECK_EN is defined.
module mem_align
  import common::*;
(
  input  decoded_op_t i_op,
  input  logic [2:0]  i_addr_lo,
  input  word_t       i_data,
  output msize_t      o_size,
  output strobe_t     o_strobe,
  output word_t       o_data,
  output logic        o_misalign
);

  always_comb begin
    o_size     = MSIZE8;
    o_strobe   = 8'h00;
    o_data     = i_data << {i_addr_lo, 3'b000};
    o_misalign = 1'b0;
    case (i_op)
      OP_LD: begin
        o_data     = '0;
        o_misalign = |i_addr_lo;
      end
      OP_SD: begin
        o_strobe   = 8'hFF;
        o_misalign = |i_addr_lo;
      end
      OP_SW: begin
        o_size     = MSIZE4;
        o_strobe   = 8'h0F << {i_addr_lo[2], 2'b00};
        o_misalign = |i_addr_lo[1:0];
      end
      OP_SH: begin
        o_size     = MSIZE2;
        o_strobe   = 8'h03 << {i_addr_lo[2:1], 1'b0};
        o_misalign = i_addr_lo[0];
      end
      OP_SB: begin
        o_size   = MSIZE1;
        o_strobe = 8'h01 << i_addr_lo;
      end
      default: begin
        o_data = '0;
      end
    endcase
`ifndef MEM_MISALIGN_CHECK_EN
    o_misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: IDLE/BUS FSM driving the data bus for loads/stores and
// registering the writeback bundle. Optional misalign trap: MEM_MISALIGN_CHECK_EN.
module memory_stage
  import common::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          dataE_valid,
  output logic          dataE_ready,
  output memory_data_t  dataM,
  output logic          dataM_valid,
  output logic          err_misalign,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp
);

  mem_state_t   r_state;
  addr_t        r_pc;
  control_t     r_ctl;
  creg_addr_t   r_dst;
  addr_t        r_addr;
  msize_t       r_size;
  strobe_t      r_strobe;
  word_t        r_wdata;
  memory_data_t r_dataM;
  logic         r_dataM_valid;

  msize_t  w_size;
  strobe_t w_strobe;
  word_t   w_wdata;
  logic    w_misalign;
  logic    w_accept;

  // Alignment is resolved at accept time and held, so dreq stays constant in BUS.
  mem_align u_align (
    .i_op       (dataE.ctl.op),
    .i_addr_lo  (dataE.mem_addr[2:0]),
    .i_data     (dataE.result),
    .o_size     (w_size),
    .o_strobe   (w_strobe),
    .o_data     (w_wdata),
    .o_misalign (w_misalign)
  );

  assign dataE_ready = (r_state == IDLE);
  assign w_accept    = dataE_valid && dataE_ready;
  assign dataM       = r_dataM;
  assign dataM_valid = r_dataM_valid;

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_err;
  assign err_misalign = r_err;
`else
  assign err_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_ctl         <= '0;
      r_dst         <= '0;
      r_addr        <= '0;
      r_size        <= MSIZE1;
      r_strobe      <= '0;
      r_wdata       <= '0;
      r_dataM       <= '0;
      r_dataM_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_err         <= 1'b0;
`endif
    end else begin
      r_dataM_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_err         <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pc     <= dataE.pc;
            r_ctl    <= dataE.ctl;
            r_dst    <= dataE.dst;
            r_addr   <= dataE.mem_addr;
            r_size   <= w_size;
            r_strobe <= w_strobe;
            r_wdata  <= w_wdata;
            if (!is_mem_op(dataE.ctl.op)) begin
              r_dataM       <= '{pc: dataE.pc, ctl: dataE.ctl, dst: dataE.dst,
                                 result: dataE.result};
              r_dataM_valid <= 1'b1;
            end else if (w_misalign) begin
              r_dataM       <= '{pc: dataE.pc, ctl: dataE.ctl, dst: dataE.dst,
                                 result: '0};
              r_dataM_valid <= 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
              r_err         <= 1'b1;
`endif
            end else begin
              r_state <= BUS;
            end
          end
        end
        BUS: begin
          // addr_ok is not needed: the request is simply held until data_ok.
          if (dresp.data_ok) begin
            r_state       <= IDLE;
            r_dataM       <= '{pc: r_pc, ctl: r_ctl, dst: r_dst,
                               result: (r_ctl.op == OP_LD) ? dresp.data : '0};
            r_dataM_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Combinational from the state register so an async reset drops valid at once.
  always_comb begin
    dreq = '0;
    if (r_state == BUS) begin
      dreq.valid  = 1'b1;
      dreq.addr   = r_addr;
      dreq.size   = r_size;
      dreq.strobe = r_strobe;
      dreq.data   = r_wdata;
    end
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage between `execute` and writeback in the in-order RV64 core. It takes the execute-stage bundle (`execute_data_t`) and drives the data bus for LD/SD/SW/SH/SB. It aligns store data and byte strobes, waits out the bus handshake, and emits a registered `memory_data_t` bundle for writeback. Non-memory instructions pass through with one-cycle latency.

## Interface
- No parameters; all widths come from package `common`.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-low reset.
- `dataE` in `execute_data_t`: `pc`, `ctl` (`op`), `dst`, `mem_addr`, `result`. For stores, `result` holds the store data.
- `dataE_valid` in 1: `dataE` holds a real instruction.
- `dataE_ready` out 1: stage accepts `dataE` this cycle.
- `dataM` out `memory_data_t`: `pc`, `ctl`, `dst`, `result` (load data or passed-through ALU result).
- `dataM_valid` out 1: one-cycle pulse marking `dataM` as valid for writeback.
- `err_misalign` out 1: qualifies `dataM_valid`; the access was misaligned and suppressed.
- `dreq` out `dbus_req_t`: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp` in `dbus_resp_t`: `addr_ok`, `data_ok`, `data`.

## Operation
- FSM states: `IDLE` and `BUS`.
- `dataE_ready` = (state == `IDLE`).
- Accept = `dataE_valid & dataE_ready`. On accept, `dataE` is latched into internal registers.
- Accept of a non-memory op: stay in `IDLE`. Next cycle, `dataM` = latched fields with `result` = `dataE.result`, and `dataM_valid` = 1.
- Accept of a memory op (aligned, or check compiled out): go to `BUS`.
- In `BUS`, `dreq` is driven combinationally from the latched registers:
  - `valid` = 1, `addr` = `mem_addr`.
  - LD: `size` = `MSIZE8`, `strobe` = 0.
  - SD: `MSIZE8`, `strobe` = 8'hFF.
  - SW: `MSIZE4`, `strobe` = 8'h0F << {addr[2],2'b0}.
  - SH: `MSIZE2`, `strobe` = 8'h03 << {addr[2:1],1'b0}.
  - SB: `MSIZE1`, `strobe` = 8'h01 << addr[2:0].
  - `data` = store data << (8·addr[2:0]), truncated to 64 bits.
- `dresp.addr_ok` is ignored. `dreq` stays valid and constant until `dresp.data_ok`.
- On `data_ok` in `BUS`: go to `IDLE` and register `dataM` with `dataM_valid` = 1 next cycle.
  - LD: `result` = `dresp.data`.
  - Stores: `result` = 0, and `dst` is passed unchanged (decode sets `dst` = 0 for stores).
- A new accept can happen in the same cycle that `dataM_valid` is high, because the FSM is already back in `IDLE`.
- Writeback never stalls, so there is no `dataM` ready signal.

## Timing
- Reset values: state `IDLE`, `dataM` = 0, `dataM_valid` = 0, `err_misalign` = 0, `dreq.valid` = 0. `dataE_ready` = 1 once reset deasserts.
- Reset asserted mid-`BUS`: `dreq.valid` drops immediately (asynchronous path through the state register). The transaction is abandoned and no `dataM_valid` is issued.
- Non-memory latency: accept in cycle N → `dataM_valid` in N+1.
- Memory latency: accept in N → `dreq.valid` in N+1 → `data_ok` in cycle N+1+k (k ≥ 0) → `dataM_valid` in N+2+k.
- `data_ok` in the first `BUS` cycle is legal (k = 0).
- `data_ok` seen while in `IDLE` is ignored.
- `dataE_ready` is 0 for every `BUS` cycle.

## Configuration
- Macro: `MEM_MISALIGN_CHECK_EN`.
- Defined: an access with addr[2:0] ≠ 0 (SD/LD), addr[1:0] ≠ 0 (SW) or addr[0] ≠ 0 (SH) does not enter `BUS`. Instead, `dataM_valid` and `err_misalign` both pulse at N+1, with `result` = 0.
- Undefined: no check is performed. `err_misalign` is tied 0 and `dreq.addr` carries the raw address.

## Structure
- Package `common`: `memory_data_t` and `mem_state_t` go here. `msize_t`, `strobe_t`, `dbus_req_t` and `dbus_resp_t` already live here.
- Sub-module `mem_align` (combinational): from op, addr[2:0] and store data, produces `size`, `strobe`, shifted data and the misalign flag.
- `memory_stage` holds the FSM, the latched input registers and the `dataM` register.

## Test plan
- ADD result 0x5, accepted at N → `dataM_valid` at N+1 with `result` = 0x5; `dreq.valid` never rises.
- LD, addr 0x80001000, `data_ok` asserted 3 cycles after `dreq.valid` with data 0xDEADBEEF_CAFEF00D → `dataM.result` = that value; `dataE_ready` low for 4 cycles.
- SB, addr 0x80000003, data 0xAB → `strobe` = 8'h08, `data` = 0x00000000AB000000, `size` = `MSIZE1`.
- SH, addr 0x80000006, data 0x1234 → `strobe` = 8'hC0, `data` = 0x1234000000000000.
- Reset asserted 1 cycle into `BUS` → `dreq.valid` falls in the same cycle; no `dataM_valid` ever appears; the next LD completes normally.
- With `MEM_MISALIGN_CHECK_EN`: SW at addr 0x80000002 → no `dreq.valid`; `err_misalign` = 1 and `dataM_valid` = 1 at N+1.
